// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: opcodes, NOP word and fetch FSM state encoding.
package mips_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2b;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_BNE   = 6'h05;
  localparam logic [OPW-1:0] OP_HALT  = 6'h3f;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  // Word-align a byte address.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC selection: hold, sequential +4, or aligned redirect.
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_inc
);

  assign pc_inc = pc + 32'd4;

  // Redirect outranks sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= align_word(RESET_PC);
    end else if (redirect) begin
      pc <= align_word(target);
    end else if (advance) begin
      pc <= pc_inc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives instruction memory, holds the output instruction register, handles redirects and HALT.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  OP_HALT  = mips_pkg::OP_HALT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [31:0] fetch_count
);
  import mips_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inc;
  logic            free;
  logic            redirect;
  logic            transfer;

  assign free      = !instr_valid || !stall;
  assign redirect  = br_taken && (state != FS_IDLE);
  assign imem_req  = (state == FS_RUN) && free && !br_taken;
  assign imem_addr = pc;
  assign transfer  = imem_req && imem_ready;
  assign opcode    = instr[31:26];

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (transfer),
    .redirect (redirect),
    .target   (br_target),
    .pc       (pc),
    .pc_inc   (pc_inc)
  );

  // FSM, output register and fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FS_IDLE;
      instr_valid <= 1'b0;
      instr       <= NOP_WORD;
      instr_pc    <= 32'h0;
      pc_plus4    <= 32'h0;
      halted      <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        FS_IDLE: state <= FS_RUN;
        FS_RUN: begin
          if (transfer && (imem_rdata[31:26] == OP_HALT)) begin
            state  <= FS_HALTED;
            halted <= 1'b1;
          end
        end
        FS_HALTED: begin
          if (br_taken) begin
            state  <= FS_RUN;
            halted <= 1'b0;
          end
        end
        default: state <= FS_IDLE;
      endcase

      // Redirect squashes the held word; otherwise load, drain, or hold.
      if (redirect) begin
        instr_valid <= 1'b0;
        instr       <= NOP_WORD;
      end else if (transfer) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        pc_plus4    <= pc_inc;
        instr_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end else if (instr_valid && !stall) begin
        instr_valid <= 1'b0;
        instr       <= NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a transaction-level fetch model.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall = 1'b0, br_taken = 1'b0, imem_ready = 1'b1;
  logic [31:0] br_target = 32'h0;
  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pc_plus4, fetch_count;
  logic [5:0]  opcode;
  logic        w_imem_req, w_instr_valid, w_halted;
  logic [31:0] w_imem_addr, w_imem_rdata, w_instr, w_instr_pc, w_pc_plus4, w_fetch_count;
  logic [5:0]  w_opcode;

  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h0;
  int n_checks = 0;
  int n_errors = 0;

  // Memory image: word at byte address a is a (top opcode bits cleared), HALT optionally planted.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic he, input logic [31:0] ha);
    if (he && a == ha) return 32'hFC00_0000;
    return {6'b0, a[25:0]};
  endfunction

  assign imem_rdata   = mem_word(imem_addr, halt_en, halt_addr);
  assign w_imem_rdata = mem_word(w_imem_addr, 1'b0, 32'h0);

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .instr_valid(instr_valid),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .halted(halted), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(w_imem_rdata), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .instr_valid(w_instr_valid),
    .instr(w_instr), .opcode(w_opcode), .instr_pc(w_instr_pc), .pc_plus4(w_pc_plus4),
    .halted(w_halted), .fetch_count(w_fetch_count)
  );

  // Reference model state for the default-parameter instance.
  bit          m_started, m_halted, m_valid;
  logic [31:0] m_pc, m_instr, m_ipc, m_count;

  function automatic bit m_req();
    return m_started && !m_halted && (!m_valid || !stall) && !br_taken;
  endfunction

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_valid = 0;
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_count = 32'h0;
  endtask

  task automatic set_in(input bit s, input bit r, input bit b, input logic [31:0] t);
    stall = s; imem_ready = r; br_taken = b; br_target = t;
    #1;
  endtask

  // One clock: apply the fetch rules to the model alongside the DUT edge.
  task automatic tick();
    bit req;
    logic [31:0] w;
    req = m_req();
    w = mem_word(m_pc, halt_en, halt_addr);
    @(posedge clk);
    if (!m_started) m_started = 1;
    else if (br_taken) begin
      m_pc = {br_target[31:2], 2'b00}; m_valid = 0; m_instr = 32'h0; m_halted = 0;
    end else if (req && imem_ready) begin
      m_instr = w; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1; m_count = m_count + 32'd1;
      if (w[31:26] == 6'h3f) m_halted = 1;
    end else if (m_valid && !stall) begin
      m_valid = 0; m_instr = 32'h0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 1, 0, 32'h0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    n_checks++; if (fetch_count !== 32'h0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
    n_checks++; if (halted !== 1'b0 || imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_halt_req got %0b%0b exp 00", halted, imem_req); end
    n_checks++; if (instr_pc !== 32'h0 || pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_pcs got %h %h %h exp 0", instr_pc, pc_plus4, imem_addr); end
    tick();
    n_checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_errors++; $display("FAIL cycle1 req/valid got %0b/%0b exp 1/0", imem_req, instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_errors++; $display("FAIL cycle2 valid/pc got %0b/%h exp 1/0", instr_valid, instr_pc); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++; if (instr_pc !== 32'(i * 4) || instr !== 32'(i * 4) || fetch_count !== 32'(i + 1))
        begin n_errors++; $display("FAIL b2b[%0d] pc/instr/cnt got %h/%h/%0d exp %h/%h/%0d", i, instr_pc, instr, fetch_count, i*4, i*4, i+1); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    set_in(1, 1, 0, 32'h0);
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL stall_req got %0b exp 0", imem_req); end
    repeat (3) begin
      tick();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || fetch_count !== 32'd1 || imem_req !== 1'b0)
        begin n_errors++; $display("FAIL stall_hold got v%0b pc %h cnt %0d req %0b exp v1 pc 0 cnt 1 req 0", instr_valid, instr_pc, fetch_count, imem_req); end
    end
    set_in(0, 1, 0, 32'h0);
    tick();
    n_checks++; if (instr_pc !== 32'h4 || fetch_count !== 32'd2 || imem_addr !== 32'h8)
      begin n_errors++; $display("FAIL stall_release got pc %h cnt %0d addr %h exp 4 2 8", instr_pc, fetch_count, imem_addr); end
  endtask

  task automatic test_ready_toggle();
    do_reset();
    tick(); tick();
    tick();
    n_checks++; if (instr_pc !== 32'h4 || fetch_count !== 32'd2) begin n_errors++; $display("FAIL rdy1 got pc %h cnt %0d exp 4 2", instr_pc, fetch_count); end
    set_in(0, 0, 0, 32'h0);
    repeat (2) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_errors++; $display("FAIL rdy0_req got %0b addr %h exp 1 8", imem_req, imem_addr); end
      tick();
      n_checks++; if (instr_valid !== 1'b0 || fetch_count !== 32'd2 || imem_addr !== 32'h8)
        begin n_errors++; $display("FAIL rdy0_hold got v%0b cnt %0d addr %h exp v0 2 8", instr_valid, fetch_count, imem_addr); end
    end
    set_in(0, 1, 0, 32'h0);
    tick();
    n_checks++; if (instr_pc !== 32'h8 || instr_valid !== 1'b1 || fetch_count !== 32'd3) begin n_errors++; $display("FAIL rdy_resume got pc %h v%0b cnt %0d exp 8 1 3", instr_pc, instr_valid, fetch_count); end
    tick();
    n_checks++; if (instr_pc !== 32'hC || fetch_count !== 32'd4) begin n_errors++; $display("FAIL rdy_next got pc %h cnt %0d exp c 4", instr_pc, fetch_count); end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(); tick();
    set_in(1, 1, 0, 32'h0);
    tick();
    set_in(1, 1, 1, 32'h0000_0043);
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL br_req got %0b exp 0", imem_req); end
    tick();
    n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== 32'h40)
      begin n_errors++; $display("FAIL br_squash got v%0b instr %h addr %h exp v0 0 40", instr_valid, instr, imem_addr); end
    set_in(0, 1, 0, 32'h0);
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL br_resume_req got %0b exp 1", imem_req); end
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || pc_plus4 !== 32'h44)
      begin n_errors++; $display("FAIL br_target_fetch got v%0b pc %h p4 %h exp v1 40 44", instr_valid, instr_pc, pc_plus4); end
  endtask

  task automatic test_halt();
    halt_addr = 32'h8; halt_en = 1'b1;
    do_reset();
    repeat (4) tick();
    n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b1 || opcode !== 6'h3f || instr !== 32'hFC00_0000 || instr_pc !== 32'h8 || fetch_count !== 32'd3)
      begin n_errors++; $display("FAIL halt_load got h%0b v%0b op %h instr %h pc %h cnt %0d exp h1 v1 3f fc000000 8 3", halted, instr_valid, opcode, instr, instr_pc, fetch_count); end
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL halt_req got %0b exp 0", imem_req); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL halt_consume got %0b exp 0", instr_valid); end
    repeat (3) begin
      tick();
      n_checks++; if (imem_req !== 1'b0 || fetch_count !== 32'd3 || halted !== 1'b1)
        begin n_errors++; $display("FAIL halt_park got req %0b cnt %0d h%0b exp 0 3 1", imem_req, fetch_count, halted); end
    end
    set_in(0, 1, 1, 32'h0);
    tick();
    n_checks++; if (halted !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0)
      begin n_errors++; $display("FAIL halt_wake got h%0b addr %h v%0b exp 0 0 0", halted, imem_addr, instr_valid); end
    set_in(0, 1, 0, 32'h0);
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || fetch_count !== 32'd4)
      begin n_errors++; $display("FAIL halt_refetch got v%0b pc %h cnt %0d exp 1 0 4", instr_valid, instr_pc, fetch_count); end
    halt_en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    halt_en = 1'b1;
    halt_addr = 32'($urandom_range(4, 40)) * 32'd4;
    for (int c = 0; c < 600; c++) begin
      set_in($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 1, 32'($urandom_range(0, 255)));
      n_checks++; if (imem_req !== m_req() || imem_addr !== m_pc)
        begin n_errors++; $display("FAIL rnd_req[%0d] got %0b %h exp %0b %h", c, imem_req, imem_addr, m_req(), m_pc); end
      tick();
      n_checks++; if (instr_valid !== m_valid || instr !== m_instr || opcode !== m_instr[31:26] || halted !== m_halted || fetch_count !== m_count)
        begin n_errors++; $display("FAIL rnd_out[%0d] got v%0b %h op %h h%0b cnt %0d exp v%0b %h op %h h%0b cnt %0d", c, instr_valid, instr, opcode, halted, fetch_count, m_valid, m_instr, m_instr[31:26], m_halted, m_count); end
      if (m_valid) begin
        n_checks++; if (instr_pc !== m_ipc || pc_plus4 !== m_ipc + 32'd4)
          begin n_errors++; $display("FAIL rnd_pc[%0d] got %h %h exp %h %h", c, instr_pc, pc_plus4, m_ipc, m_ipc + 32'd4); end
      end
    end
    halt_en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || fetch_count !== 32'h0 || imem_req !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h0)
      begin n_errors++; $display("FAIL async_rst got v%0b %h cnt %0d req %0b h%0b addr %h exp all 0", instr_valid, instr, fetch_count, imem_req, halted, imem_addr); end
    n_checks++; if (w_fetch_count !== 32'h0 || w_imem_addr !== 32'hFFFF_FFFC)
      begin n_errors++; $display("FAIL async_rst_w got cnt %0d addr %h exp 0 fffffffc", w_fetch_count, w_imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(); tick();
    n_checks++; if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'h0 || w_imem_addr !== 32'h0)
      begin n_errors++; $display("FAIL wrap_first got v%0b pc %h p4 %h addr %h exp 1 fffffffc 0 0", w_instr_valid, w_instr_pc, w_pc_plus4, w_imem_addr); end
    tick();
    n_checks++; if (w_instr_pc !== 32'h0 || w_fetch_count !== 32'd2 || w_instr_valid !== 1'b1)
      begin n_errors++; $display("FAIL wrap_second got pc %h cnt %0d v%0b exp 0 2 1", w_instr_pc, w_fetch_count, w_instr_valid); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stall();
    test_ready_toggle();
    test_redirect();
    test_halt();
    test_random();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
